elevator_ctrl_n: RTL
====================

Name: elevator_ctrl_n

Overview:
- Parametrised elevator controller for an N-floor car.
- Latches cabin and hall calls and serves them in SCAN order: keep the current direction while requests remain ahead.
- Drives the motor command and door, with a programmable door dwell and a hold extension.
- Sits between the button/sensor inputs and the motor/door/display outputs at the top level, replacing the fixed 4-floor controller.

Parameters:
- NUM_FLOORS, 4, number of floors (2..16). Floors are indexed 0..NUM_FLOORS-1; floor 0 is the bottom.
- DOOR_CYCLES, 8, clk cycles the door stays open after the last reload (>=2).
- FW, $clog2(NUM_FLOORS), width of the floor index (localparam, not overridable).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- car_req  in  NUM_FLOORS  cabin floor buttons, level-sensitive, one bit per floor.
- up_req  in  NUM_FLOORS  hall up buttons; bit NUM_FLOORS-1 is ignored.
- dn_req  in  NUM_FLOORS  hall down buttons; bit 0 is ignored.
- floor_sens  in  NUM_FLOORS  floor sensors; one-hot at a floor, all-zero between floors.
- hold  in  1  door-hold button.
- ac  out  2  motor command: 00 stop, 01 up, 10 down; 11 is never driven.
- open  out  1  door open.
- disp  out  FW  current floor index.
- lamp  out  NUM_FLOORS  per-floor "request pending" (OR of the latched car/up/down calls).

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, dir=UP, cur_floor=0, door counter=0, all request latches=0.
  - Outputs: ac=00, open=0, disp=0, lamp=0.
  - Applies immediately, including mid-move and with the door open.
- Outputs are Moore: decoded from registered state/cur_floor only, never from inputs.
- Request latches (car_l, up_l, dn_l):
  - Set on the cycle after the button is seen high; they stay set after release.
  - Cleared only by service (below).
  - Set and clear on the same cycle at the same floor: clear wins while the door is open there; otherwise set wins.
- cur_floor:
  - Loads the index of floor_sens when exactly one bit is set.
  - Zero or multiple bits set: holds its value (multi-hot is treated as a sensor glitch).
  - disp = cur_floor.
- "ahead" means any latched request at an index strictly beyond cur_floor in dir; "here" means any latch at cur_floor relevant to the rule in use.
- States:
  - IDLE: ac=00, open=0.
    - Any latch at cur_floor -> DOOR_OPEN.
    - Else requests ahead in dir -> MOVE in dir.
    - Else requests behind -> flip dir, MOVE.
    - Else stay in IDLE.
  - MOVE_UP: ac=01. On a cycle where floor_sens is one-hot at floor f > the floor of departure, stop -> DOOR_OPEN if any of:
    - car_l[f] set;
    - up_l[f] set;
    - no latches above f (covers a down call at the turn-around);
    - f = NUM_FLOORS-1 (forced end stop).
  - MOVE_DN: ac=10. Symmetric to MOVE_UP, using dn_l; forced stop at floor 0.
  - DOOR_OPEN: ac=00, open=1.
    - Counter loads DOOR_CYCLES-1 on entry and counts down.
    - hold=1 reloads the counter every cycle it is high.
    - A new car/hall press at cur_floor (matching rule) reloads the counter and is cleared.
    - Counter 0 with hold=0 -> IDLE.
- Service clear on entry to DOOR_OPEN at floor f:
  - car_l[f] is cleared.
  - Moving UP: up_l[f] is cleared; dn_l[f] is cleared too if there are no latches above f.
  - Moving DN: symmetric.
  - Coming from IDLE: the call in dir is cleared, else the other one.
- Safety invariant: open=1 implies ac=00 on every cycle. Direction reversal always passes through DOOR_OPEN or IDLE.
- Requests at cur_floor while in MOVE are ignored until the next arrival; the car does not reverse mid-travel.
- Latency:
  - Press at the idle car's floor -> open=1 two cycles later (latch, then state).
  - Arrival sensor at a served floor -> ac=00 and open=1 on the next cycle.

Decomposition:
- Shared package: state encoding (IDLE, MOVE_UP, MOVE_DN, DOOR_OPEN), AC_STOP/AC_UP/AC_DN constants, DIR_UP/DIR_DN.
- Natural sub-module: elevator_req_latch. It holds the three latch vectors with set/clear and produces the ahead-above/ahead-below/here flags for a given cur_floor.
- The FSM and door counter stay in elevator_ctrl_n.

Test Plan (NUM_FLOORS=4, DOOR_CYCLES=4, clk period 2):
- Reset with floor_sens=0001, then release:
  - ac=00, open=0, disp=0, lamp=0000.
  - Assert reset=0 mid-MOVE_UP -> ac=00 immediately.
- Idle at 0, pulse car_req[0] -> open=1 two cycles later, open for exactly 4 cycles, then IDLE; lamp[0] clears when the door opens.
- Idle at 0, pulse car_req[2] and dn_req[3]:
  - ac=01; pass floor 1 without stopping; stop at 2 (open 4 cycles).
  - Continue up, stop at 3; dn_l[3] clears there.
  - Then IDLE, disp=3.
- Moving up from 0 toward 3 (car_req[3]), press dn_req[1] while the sensor shows floor 1 -> no stop at 1; serve 3; reverse; stop at 1.
- DOOR_OPEN at 2 with hold held for 10 cycles -> open stays 1 for 10+4 cycles; ac stays 00 throughout.
- floor_sens=0110 (multi-hot) while moving -> disp is unchanged and no stop occurs; the next one-hot value updates disp.

Source files
------------

// File: rtl/elevator_ctrl_n_pkg.sv
// Shared encodings for the SCAN elevator controller: FSM states, travel direction
// and motor command values.
package elevator_ctrl_n_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DN   = 2'd2,
        DOOR_OPEN = 2'd3
    } state_t;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_t;

    localparam logic [1:0] AC_STOP = 2'b00;
    localparam logic [1:0] AC_UP   = 2'b01;
    localparam logic [1:0] AC_DN   = 2'b10;

endpackage

// File: rtl/elevator_req_latch.sv
// Cabin/hall call latches with service clear, plus the above/below/here flags
// evaluated at the floor the controller is currently deciding for.
module elevator_req_latch #(
    parameter int NUM_FLOORS = 4,
    parameter int FW         = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] car_req,
    input  logic [NUM_FLOORS-1:0] up_req,
    input  logic [NUM_FLOORS-1:0] dn_req,
    input  logic [NUM_FLOORS-1:0] clr_car,
    input  logic [NUM_FLOORS-1:0] clr_up,
    input  logic [NUM_FLOORS-1:0] clr_dn,
    input  logic                  clr_wins,
    input  logic [FW-1:0]         at_floor,
    output logic [NUM_FLOORS-1:0] lamp,
    output logic                  above,
    output logic                  below,
    output logic                  car_here,
    output logic                  up_here,
    output logic                  dn_here
);

    logic [NUM_FLOORS-1:0] car_l, up_l, dn_l;
    logic [NUM_FLOORS-1:0] car_n, up_n, dn_n;
    logic [NUM_FLOORS-1:0] above_m, below_m;

    // With the door open at a floor a fresh press there is absorbed (clear wins);
    // on the service-entry cycle a simultaneous press survives (set wins).
    always_comb begin
        if (clr_wins) begin
            car_n = (car_l | car_req) & ~clr_car;
            up_n  = (up_l  | up_req)  & ~clr_up;
            dn_n  = (dn_l  | dn_req)  & ~clr_dn;
        end else begin
            car_n = (car_l & ~clr_car) | car_req;
            up_n  = (up_l  & ~clr_up)  | up_req;
            dn_n  = (dn_l  & ~clr_dn)  | dn_req;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            car_l <= '0;
            up_l  <= '0;
            dn_l  <= '0;
        end else begin
            car_l <= car_n;
            up_l  <= up_n;
            dn_l  <= dn_n;
        end
    end

    assign lamp = car_l | up_l | dn_l;

    always_comb begin
        above_m = '0;
        below_m = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            above_m[i] = (FW'(i) > at_floor);
            below_m[i] = (FW'(i) < at_floor);
        end
    end

    assign above    = |(lamp & above_m);
    assign below    = |(lamp & below_m);
    assign car_here = car_l[at_floor];
    assign up_here  = up_l[at_floor];
    assign dn_here  = dn_l[at_floor];

endmodule

// File: rtl/elevator_ctrl_n.sv
// N-floor SCAN elevator controller: motor/door FSM, door dwell counter and floor
// tracking around the request latch block.
module elevator_ctrl_n #(
    parameter int NUM_FLOORS  = 4,
    parameter int DOOR_CYCLES = 8,
    localparam int FW         = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] car_req,
    input  logic [NUM_FLOORS-1:0] up_req,
    input  logic [NUM_FLOORS-1:0] dn_req,
    input  logic [NUM_FLOORS-1:0] floor_sens,
    input  logic                  hold,
    output logic [1:0]            ac,
    output logic                  open,
    output logic [FW-1:0]         disp,
    output logic [NUM_FLOORS-1:0] lamp
);
    import elevator_ctrl_n_pkg::*;

    localparam int              CW        = $clog2(DOOR_CYCLES);
    localparam logic [FW-1:0]   TOP_FLOOR = FW'(NUM_FLOORS - 1);
    localparam logic [CW-1:0]   DOOR_LOAD = CW'(DOOR_CYCLES - 1);

    state_t                state;
    dir_t                  dir;
    logic [FW-1:0]         cur_floor, sens_idx, at_floor;
    logic [CW-1:0]         door_cnt;
    logic                  sens_hit, moving;
    logic [NUM_FLOORS-1:0] sel, up_v, dn_v, clr_car, clr_up, clr_dn;
    logic                  above, below, car_here, up_here, dn_here;
    logic                  here_any, go_up, go_dn, stop_up, stop_dn, press_here;

    always_comb begin
        sens_idx = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (floor_sens[i]) sens_idx = FW'(i);
        end
        sens_hit = ($countones(floor_sens) == 1);
    end

    // Hall buttons that have no meaning at the end floors are dropped here.
    always_comb begin
        up_v = up_req;
        up_v[NUM_FLOORS-1] = 1'b0;
        dn_v = dn_req;
        dn_v[0] = 1'b0;
    end

    elevator_req_latch #(
        .NUM_FLOORS(NUM_FLOORS),
        .FW        (FW)
    ) u_req (
        .clk     (clk),
        .reset   (reset),
        .car_req (car_req),
        .up_req  (up_v),
        .dn_req  (dn_v),
        .clr_car (clr_car),
        .clr_up  (clr_up),
        .clr_dn  (clr_dn),
        .clr_wins(state == DOOR_OPEN),
        .at_floor(at_floor),
        .lamp    (lamp),
        .above   (above),
        .below   (below),
        .car_here(car_here),
        .up_here (up_here),
        .dn_here (dn_here)
    );

    // While travelling, flags are taken at the floor just arriving, not the
    // registered one, so the stop decision lands on the arrival cycle.
    always_comb begin
        moving   = (state == MOVE_UP) || (state == MOVE_DN);
        at_floor = (moving && sens_hit) ? sens_idx : cur_floor;
        sel      = '0;
        sel[at_floor] = 1'b1;
        here_any = car_here | up_here | dn_here;
        go_up    = (dir == DIR_UP) ? above : (above && !below);
        go_dn    = (dir == DIR_DN) ? below : (below && !above);
        stop_up  = (state == MOVE_UP) && sens_hit && (sens_idx > cur_floor) &&
                   (car_here || up_here || !above || (sens_idx == TOP_FLOOR));
        stop_dn  = (state == MOVE_DN) && sens_hit && (sens_idx < cur_floor) &&
                   (car_here || dn_here || !below || (sens_idx == '0));
        clr_car    = '0;
        clr_up     = '0;
        clr_dn     = '0;
        press_here = 1'b0;
        case (state)
            IDLE: begin
                if (here_any) begin
                    clr_car = sel;
                    if (dir == DIR_UP) begin
                        if (up_here) clr_up = sel;
                        else         clr_dn = sel;
                    end else begin
                        if (dn_here) clr_dn = sel;
                        else         clr_up = sel;
                    end
                end
            end
            MOVE_UP: begin
                if (stop_up) begin
                    clr_car = sel;
                    clr_up  = sel;
                    if (!above) clr_dn = sel;
                end
            end
            MOVE_DN: begin
                if (stop_dn) begin
                    clr_car = sel;
                    clr_dn  = sel;
                    if (!below) clr_up = sel;
                end
            end
            DOOR_OPEN: begin
                clr_car = sel;
                if (dir == DIR_UP) begin
                    clr_up = sel;
                    if (!above) clr_dn = sel;
                end else begin
                    clr_dn = sel;
                    if (!below) clr_up = sel;
                end
                press_here = |(sel & (car_req | (clr_up & up_v) | (clr_dn & dn_v)));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            dir       <= DIR_UP;
            cur_floor <= '0;
            door_cnt  <= '0;
            ac        <= AC_STOP;
            open      <= 1'b0;
        end else begin
            if (sens_hit) cur_floor <= sens_idx;
            case (state)
                IDLE: begin
                    if (here_any) begin
                        state    <= DOOR_OPEN;
                        door_cnt <= DOOR_LOAD;
                        open     <= 1'b1;
                        ac       <= AC_STOP;
                    end else if (go_up) begin
                        state <= MOVE_UP;
                        dir   <= DIR_UP;
                        ac    <= AC_UP;
                    end else if (go_dn) begin
                        state <= MOVE_DN;
                        dir   <= DIR_DN;
                        ac    <= AC_DN;
                    end
                end
                MOVE_UP: begin
                    if (stop_up) begin
                        state    <= DOOR_OPEN;
                        door_cnt <= DOOR_LOAD;
                        open     <= 1'b1;
                        ac       <= AC_STOP;
                    end
                end
                MOVE_DN: begin
                    if (stop_dn) begin
                        state    <= DOOR_OPEN;
                        door_cnt <= DOOR_LOAD;
                        open     <= 1'b1;
                        ac       <= AC_STOP;
                    end
                end
                DOOR_OPEN: begin
                    if (hold || press_here) begin
                        door_cnt <= DOOR_LOAD;
                    end else if (door_cnt == '0) begin
                        state <= IDLE;
                        open  <= 1'b0;
                    end else begin
                        door_cnt <= door_cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign disp = cur_floor;

endmodule
